// File: rtl/led_pattern_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_pkg
//  Description : Shared types and constants for the LED test-pattern source.
//                Pattern mode encoding, FSM state encoding, checker bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pattern_pkg;

    // Pattern select encoding as seen on mode_i; 5-7 are reserved (all zeros)
    typedef enum logic [2:0] {
        MODE_ALL_ON  = 3'd0,
        MODE_CHECKER = 3'd1,
        MODE_WALK    = 3'd2,
        MODE_RAMP    = 3'd3,
        MODE_OFF     = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT    = 2'd1,
        WAIT_PHY = 2'd2
    } state_e;

    localparam logic [7:0] c_BYTE_55 = 8'h55;
    localparam logic [7:0] c_BYTE_AA = 8'hAA;

endpackage : led_pattern_pkg
`default_nettype wire

// File: rtl/led_period_timer.sv
`default_nettype none
// ============================================================================
//  Module      : led_period_timer
//  Description : Free-running period counter 0..PERIOD_CYC-1 while run_i is
//                high, held at 0 while low. tick is high in the last count.
//  Ports       : clk   - system clock
//                rstn  - asynchronous active-low reset
//                run_i - 1 = count, 0 = hold at zero
//                tick  - high while count == PERIOD_CYC-1
//  Revision    : 1.0 - initial release
// ============================================================================
module led_period_timer #(
    parameter int PERIOD_CYC = 25000
) (
    input  logic clk,
    input  logic rstn,
    input  logic run_i,
    output logic tick
);

    localparam int CW = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(PERIOD_CYC - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (!run_i) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == c_LAST);

endmodule : led_period_timer
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_gen
//  Description : LED test-pattern source for the LED PHY enable/data_in
//                interface. Issues one frame per period, holds it back while
//                the PHY is busy (at most one pending), counts frames.
//  Ports       : clk, rstn     - clock, asynchronous active-low reset
//                run_i         - 1 = generate frames
//                mode_i        - pattern select (see led_pattern_pkg)
//                phy_busy_i    - PHY still shifting previous frame
//                enable        - single-cycle frame strobe
//                data_in       - frame data, held until next strobe
//                frame_cnt_o   - issued-frame counter (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int PERIOD_CYC = 25000,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              run_i,
    input  logic [2:0]        mode_i,
    input  logic              phy_busy_i,
    output logic              enable,
    output logic [DATA_W-1:0] data_in,
    output logic [CNT_W-1:0]  frame_cnt_o
);

    localparam int IDX_W  = $clog2(DATA_W);
    localparam int NBYTES = DATA_W / 8;
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(DATA_W - 1);

    logic              w_tick;
    state_e            r_state;
    state_e            w_state_nxt;
    logic              w_issue;

    logic              r_enable;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [2:0]        r_last_mode;
    logic [IDX_W-1:0]  r_walk_idx;
    logic              r_phase;

    logic              w_mode_chg;
    logic [IDX_W-1:0]  w_walk_idx;
    logic [IDX_W-1:0]  w_walk_nxt;
    logic              w_phase;
    logic [7:0]        w_cnt_byte;
    logic [DATA_W-1:0] w_pattern;

    led_period_timer #(
        .PERIOD_CYC (PERIOD_CYC)
    ) u_timer (
        .clk   (clk),
        .rstn  (rstn),
        .run_i (run_i),
        .tick  (w_tick)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (run_i) w_state_nxt = COUNT;
            end
            COUNT: begin
                if (!run_i)                   w_state_nxt = IDLE;
                else if (w_tick && phy_busy_i) w_state_nxt = WAIT_PHY;
            end
            WAIT_PHY: begin
                // Ticks seen here are absorbed; only one frame is ever pending
                if (!run_i)           w_state_nxt = IDLE;
                else if (!phy_busy_i) w_state_nxt = COUNT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_issue = 1'b0;
        case (r_state)
            COUNT:    w_issue = run_i && w_tick && !phy_busy_i;
            WAIT_PHY: w_issue = run_i && !phy_busy_i;
            default:  w_issue = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Pattern generation
    // ------------------------------------------------------------------
    generate
        if (CNT_W >= 8) begin : g_cnt_byte_full
            assign w_cnt_byte = r_frame_cnt[7:0];
        end else begin : g_cnt_byte_pad
            assign w_cnt_byte = {{(8 - CNT_W){1'b0}}, r_frame_cnt};
        end
    endgenerate

    always_comb begin
        // A mode change makes this frame the first one of the new mode
        w_mode_chg = (mode_i != r_last_mode);
        w_walk_idx = w_mode_chg ? '0   : r_walk_idx;
        w_phase    = w_mode_chg ? 1'b0 : r_phase;
        w_walk_nxt = (w_walk_idx == c_IDX_LAST) ? '0 : w_walk_idx + 1'b1;
        case (mode_i)
            MODE_ALL_ON:  w_pattern = '1;
            MODE_CHECKER: w_pattern = {NBYTES{w_phase ? c_BYTE_AA : c_BYTE_55}};
            MODE_WALK:    w_pattern = DATA_W'(1) << w_walk_idx;
            MODE_RAMP:    w_pattern = {NBYTES{w_cnt_byte}};
            default:      w_pattern = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_enable    <= 1'b0;
            r_data      <= '0;
            r_frame_cnt <= '0;
            r_last_mode <= 3'd0;
            r_walk_idx  <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_enable <= w_issue;
            if (w_issue) begin
                r_data      <= w_pattern;
                r_frame_cnt <= r_frame_cnt + 1'b1;
                r_last_mode <= mode_i;
                if (mode_i == MODE_WALK)    r_walk_idx <= w_walk_nxt;
                if (mode_i == MODE_CHECKER) r_phase    <= ~w_phase;
            end
        end
    end

    assign enable      = r_enable;
    assign data_in     = r_data;
    assign frame_cnt_o = r_frame_cnt;

endmodule : led_pattern_gen
`default_nettype wire
